// File: rtl/speed_round_scorer.sv
// speed_round_scorer: owns the two-button speed round (timer, push counting, verdict); SPEED_DEBOUNCE_EN adds a per-button level filter.
// Latency: push pulse lands 3 cycles after first sampling edge (3+DEB_CYCLES when filtered); verdict 1 cycle after the window closes.
// Backpressure: none; pushes outside COUNT are dropped, speed_start outside IDLE/DONE is ignored, speed_abort always wins.
module speed_round_scorer #(
   parameter int CNT_W      = 8,
   parameter int ROUND_LEN  = 1000,
   parameter int TIE_MARGIN = 0
`ifdef SPEED_DEBOUNCE_EN
   , parameter int DEB_CYCLES = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pbl,
   input  logic             pbr,
   input  logic             speed_start,
   input  logic             speed_abort,
   output logic             busy,
   output logic             result_valid,
   output logic             speed_right,
   output logic             speed_left,
   output logic             speed_tie,
   output logic [CNT_W-1:0] count_left,
   output logic [CNT_W-1:0] count_right
);

   localparam int TW = (ROUND_LEN > 2) ? $clog2(ROUND_LEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_COMPARE, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_prev;
   logic [1:0]       r_pulse;
   logic [1:0]       w_lvl;
   logic [TW-1:0]    r_timer;
   logic [CNT_W-1:0] r_cnt_l;
   logic [CNT_W-1:0] r_cnt_r;
   logic             r_right;
   logic             r_left;
   logic             r_tie;
   logic [CNT_W:0]   w_diff;
   logic             w_is_tie;
   logic             w_enter_count;

   // Two-flop synchroniser; bit 0 is the left button, bit 1 the right.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {pbr, pbl};
         r_sync2 <= r_sync1;
      end
   end

`ifdef SPEED_DEBOUNCE_EN
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

   logic [DW-1:0] r_deb_l;
   logic [DW-1:0] r_deb_r;
   logic [1:0]    r_filt;

   // Filtered level only flips after DEB_CYCLES consecutive cycles at the new level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt  <= '0;
         r_deb_l <= '0;
         r_deb_r <= '0;
      end else begin
         if (r_sync2[0] == r_filt[0]) begin
            r_deb_l <= '0;
         end else if (r_deb_l == DW'(DEB_CYCLES - 1)) begin
            r_filt[0] <= r_sync2[0];
            r_deb_l   <= '0;
         end else begin
            r_deb_l <= r_deb_l + 1'b1;
         end
         if (r_sync2[1] == r_filt[1]) begin
            r_deb_r <= '0;
         end else if (r_deb_r == DW'(DEB_CYCLES - 1)) begin
            r_filt[1] <= r_sync2[1];
            r_deb_r   <= '0;
         end else begin
            r_deb_r <= r_deb_r + 1'b1;
         end
      end
   end

   assign w_lvl = r_filt;
`else
   assign w_lvl = r_sync2;
`endif

   // Registered rising-edge detect: one pulse per push however long it is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev  <= '0;
         r_pulse <= '0;
      end else begin
         r_prev  <= w_lvl;
         r_pulse <= w_lvl & ~r_prev;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; abort overrides everything including a same-cycle start.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (speed_start) w_next = S_COUNT;
         S_COUNT:   if (r_timer == '0) w_next = S_COMPARE;
         S_COMPARE: w_next = S_DONE;
         S_DONE:    if (speed_start) w_next = S_COUNT;
         default:   w_next = S_IDLE;
      endcase
      if (speed_abort) w_next = S_IDLE;
   end

   assign w_enter_count = (w_next == S_COUNT) && (r_state != S_COUNT);

   // One extra bit keeps the magnitude exact even when one counter is saturated.
   assign w_diff   = (r_cnt_r >= r_cnt_l) ? ({1'b0, r_cnt_r} - {1'b0, r_cnt_l})
                                          : ({1'b0, r_cnt_l} - {1'b0, r_cnt_r});
   assign w_is_tie = 32'(w_diff) <= 32'(TIE_MARGIN);

   // Round datapath: timer, saturating counters and the latched verdict.
   always_ff @(posedge clk) begin
      if (rst || speed_abort) begin
         r_timer <= '0;
         r_cnt_l <= '0;
         r_cnt_r <= '0;
         r_right <= 1'b0;
         r_left  <= 1'b0;
         r_tie   <= 1'b0;
      end else if (w_enter_count) begin
         r_timer <= TW'(ROUND_LEN - 1);
         r_cnt_l <= '0;
         r_cnt_r <= '0;
         r_right <= 1'b0;
         r_left  <= 1'b0;
         r_tie   <= 1'b0;
      end else begin
         if (r_state == S_COUNT) begin
            if (r_timer != '0) r_timer <= r_timer - 1'b1;
            if (r_pulse[0] && (r_cnt_l != '1)) r_cnt_l <= r_cnt_l + 1'b1;
            if (r_pulse[1] && (r_cnt_r != '1)) r_cnt_r <= r_cnt_r + 1'b1;
         end
         if (r_state == S_COMPARE) begin
            r_tie   <= w_is_tie;
            r_right <= !w_is_tie && (r_cnt_r > r_cnt_l);
            r_left  <= !w_is_tie && (r_cnt_l > r_cnt_r);
         end
      end
   end

   assign busy         = (r_state == S_COUNT) || (r_state == S_COMPARE);
   assign result_valid = (r_state == S_DONE);
   assign speed_right  = r_right;
   assign speed_left   = r_left;
   assign speed_tie    = r_tie;
   assign count_left   = r_cnt_l;
   assign count_right  = r_cnt_r;

endmodule

// File: tb/tb_speed_round_scorer.sv
// tb_speed_round_scorer: three scorer configurations driven by the same buttons, checked against a push-history model.
// Config A: 8-bit, 16-cycle round, margin 0. B: margin 2. C: 3-bit counters, 24-cycle round.
// Build with SPEED_DEBOUNCE_EN to exercise the filtered variant (DEB_CYCLES = 4).
module tb_speed_round_scorer;

   localparam int LA = 16;
   localparam int LC = 24;
`ifdef SPEED_DEBOUNCE_EN
   localparam int DEB = 4;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pbl = 1'b0;
   logic pbr = 1'b0;
   logic speed_start = 1'b0;
   logic speed_abort = 1'b0;

   logic a_busy, a_rv, a_r, a_l, a_t;
   logic b_busy, b_rv, b_r, b_l, b_t;
   logic c_busy, c_rv, c_r, c_l, c_t;
   logic [7:0] a_cl, a_cr, b_cl, b_cr;
   logic [2:0] c_cl, c_cr;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int s;
   bit hl [0:8191];
   bit hr [0:8191];
   bit pl [0:31];
   bit pr [0:31];

   always #5 clk = ~clk;

   speed_round_scorer #(.CNT_W(8), .ROUND_LEN(LA), .TIE_MARGIN(0)
`ifdef SPEED_DEBOUNCE_EN
      , .DEB_CYCLES(DEB)
`endif
   ) u_a (.clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .speed_start(speed_start), .speed_abort(speed_abort),
          .busy(a_busy), .result_valid(a_rv), .speed_right(a_r), .speed_left(a_l), .speed_tie(a_t),
          .count_left(a_cl), .count_right(a_cr));

   speed_round_scorer #(.CNT_W(8), .ROUND_LEN(LA), .TIE_MARGIN(2)
`ifdef SPEED_DEBOUNCE_EN
      , .DEB_CYCLES(DEB)
`endif
   ) u_b (.clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .speed_start(speed_start), .speed_abort(speed_abort),
          .busy(b_busy), .result_valid(b_rv), .speed_right(b_r), .speed_left(b_l), .speed_tie(b_t),
          .count_left(b_cl), .count_right(b_cr));

   speed_round_scorer #(.CNT_W(3), .ROUND_LEN(LC), .TIE_MARGIN(0)
`ifdef SPEED_DEBOUNCE_EN
      , .DEB_CYCLES(DEB)
`endif
   ) u_c (.clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .speed_start(speed_start), .speed_abort(speed_abort),
          .busy(c_busy), .result_valid(c_rv), .speed_right(c_r), .speed_left(c_l), .speed_tie(c_t),
          .count_left(c_cl), .count_right(c_cr));

   // Record the button level each clock edge sees; edge numbering starts at 1.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (cyc < 8192) begin
         hl[cyc] = pbl;
         hr[cyc] = pbr;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // Pushes counted in a round started at edge st: a rising edge of the (filtered)
   // level sampled at edge m produces a pulse counted at edge m+lat, which must fall
   // inside the counting window, edges st+1 .. st+len.
   function automatic int model_count(input bit right, input int st, input int len, input int w);
      int  n;
      int  lat;
      bit  f;
      bit  nf;
      bit  all_new;
      n = 0;
      f = 1'b0;
`ifdef SPEED_DEBOUNCE_EN
      lat = 4;
`else
      lat = 3;
`endif
      for (int m = 1; m <= st + len; m++) begin
`ifdef SPEED_DEBOUNCE_EN
         all_new = (m >= DEB);
         for (int q = 0; q < DEB; q++)
            if (m - q >= 0 && (right ? hr[m-q] : hl[m-q]) == f) all_new = 1'b0;
         nf = all_new ? ~f : f;
`else
         all_new = 1'b0;
         nf = right ? hr[m] : hl[m];
`endif
         if (nf && !f && (m + lat >= st + 1) && (m + lat <= st + len)) n++;
         f = nf | all_new & 1'b0;
      end
      if (n > (1 << w) - 1) n = (1 << w) - 1;
      return n;
   endfunction

   // 0 = tie, 1 = left wins, 2 = right wins.
   function automatic int verdict(input int l, input int r, input int tm);
      int d;
      d = (r > l) ? r - l : l - r;
      if (d <= tm) return 0;
      return (r > l) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_done(input string tag, input int st, input int len, input int w, input int tm,
                             input logic busy, input logic rv, input logic r, input logic l, input logic t,
                             input logic [31:0] cl, input logic [31:0] cr);
      int el, er, vd;
      el = model_count(1'b0, st, len, w);
      er = model_count(1'b1, st, len, w);
      vd = verdict(el, er, tm);
      chk({tag, ".busy"}, {31'd0, busy}, 0);
      chk({tag, ".valid"}, {31'd0, rv}, 1);
      chk({tag, ".count_left"}, cl, el);
      chk({tag, ".count_right"}, cr, er);
      chk({tag, ".right"}, {31'd0, r}, (vd == 2) ? 1 : 0);
      chk({tag, ".left"}, {31'd0, l}, (vd == 1) ? 1 : 0);
      chk({tag, ".tie"}, {31'd0, t}, (vd == 0) ? 1 : 0);
   endtask

   task automatic check_idle(input string tag, input logic busy, input logic rv, input logic r,
                             input logic l, input logic t, input logic [31:0] cl, input logic [31:0] cr);
      chk({tag, ".busy"}, {31'd0, busy}, 0);
      chk({tag, ".valid"}, {31'd0, rv}, 0);
      chk({tag, ".flags"}, {29'd0, r, l, t}, 0);
      chk({tag, ".count_left"}, cl, 0);
      chk({tag, ".count_right"}, cr, 0);
   endtask

   task automatic check_busy(input string tag, input logic busy, input logic rv, input logic r,
                             input logic l, input logic t);
      chk({tag, ".busy"}, {31'd0, busy}, 1);
      chk({tag, ".valid"}, {31'd0, rv}, 0);
      chk({tag, ".flags"}, {29'd0, r, l, t}, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pbl = 1'b0;
         pbr = 1'b0;
         speed_start = 1'b0;
         speed_abort = 1'b0;
      end
   endtask

   task automatic clear_pat();
      for (int j = 0; j < 32; j++) begin
         pl[j] = 1'b0;
         pr[j] = 1'b0;
      end
   endtask

   task automatic add_pushes(input bit right, input int first, input int step, input int n);
      for (int k = 0; k < n; k++) begin
         if (right) pr[first + k * step] = 1'b1;
         else       pl[first + k * step] = 1'b1;
      end
   endtask

   task automatic rand_pat();
      for (int j = 0; j < 32; j++) begin
         pl[j] = 1'($urandom_range(0, 1));
         pr[j] = 1'($urandom_range(0, 1));
      end
   endtask

   // Start a round (pl/pr[j] is the level sampled at edge st+j) and check all three
   // scorers at their COMPARE cycle and first DONE cycle; A and B are rechecked once
   // C finishes, after further pushes have landed in their DONE state.
   task automatic run_round(input string tag, output int st);
      idle(8);
      st = cyc + 1;
      speed_start = 1'b1;
      pbl = pl[0];
      pbr = pr[0];
      for (int j = 1; j <= LC + 2; j++) begin
         @(negedge clk);
         speed_start = 1'b0;
         if (j == 1) begin
            check_busy({tag, ".a.start"}, a_busy, a_rv, a_r, a_l, a_t);
            check_busy({tag, ".c.start"}, c_busy, c_rv, c_r, c_l, c_t);
            chk({tag, ".a.start.counts"}, {16'd0, a_cl, a_cr}, 0);
            chk({tag, ".c.start.counts"}, {26'd0, c_cl, c_cr}, 0);
         end
         if (j == LA + 1) begin
            check_busy({tag, ".a.compare"}, a_busy, a_rv, a_r, a_l, a_t);
            check_busy({tag, ".b.compare"}, b_busy, b_rv, b_r, b_l, b_t);
         end
         if (j == LA + 2) begin
            check_done({tag, ".a"}, st, LA, 8, 0, a_busy, a_rv, a_r, a_l, a_t, a_cl, a_cr);
            check_done({tag, ".b"}, st, LA, 8, 2, b_busy, b_rv, b_r, b_l, b_t, b_cl, b_cr);
         end
         if (j == LC + 1) check_busy({tag, ".c.compare"}, c_busy, c_rv, c_r, c_l, c_t);
         if (j == LC + 2) begin
            check_done({tag, ".c"}, st, LC, 3, 0, c_busy, c_rv, c_r, c_l, c_t, c_cl, c_cr);
            check_done({tag, ".a.hold"}, st, LA, 8, 0, a_busy, a_rv, a_r, a_l, a_t, a_cl, a_cr);
            check_done({tag, ".b.hold"}, st, LA, 8, 2, b_busy, b_rv, b_r, b_l, b_t, b_cl, b_cr);
         end
         pbl = (j < 32) ? pl[j] : 1'b0;
         pbr = (j < 32) ? pr[j] : 1'b0;
      end
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check_idle("reset.a", a_busy, a_rv, a_r, a_l, a_t, a_cl, a_cr);
      check_idle("reset.c", c_busy, c_rv, c_r, c_l, c_t, c_cl, c_cr);
      rst = 1'b0;
      idle(4);
      check_idle("idle.b", b_busy, b_rv, b_r, b_l, b_t, b_cl, b_cr);

      // 5 right, 3 left: right wins, verdict 17 cycles after start.
      clear_pat();
      add_pushes(1'b1, 0, 2, 5);
      add_pushes(1'b0, 1, 3, 3);
      run_round("r5l3", s);
`ifndef SPEED_DEBOUNCE_EN
      chk("r5l3.const.cr", {24'd0, a_cr}, 5);
      chk("r5l3.const.cl", {24'd0, a_cl}, 3);
      chk("r5l3.const.right", {31'd0, a_r}, 1);
`endif

      // 4 each with two simultaneous pushes: tie.
      clear_pat();
      add_pushes(1'b0, 0, 2, 4);
      add_pushes(1'b1, 0, 3, 4);
      run_round("tie4", s);
`ifndef SPEED_DEBOUNCE_EN
      chk("tie4.const.counts", {16'd0, a_cl, a_cr}, {16'd0, 8'd4, 8'd4});
      chk("tie4.const.tie", {31'd0, a_t}, 1);
`endif

      // Margin 2: 6 vs 4 ties on B, 7 vs 4 does not.
      clear_pat();
      add_pushes(1'b1, 0, 2, 6);
      add_pushes(1'b0, 0, 2, 4);
      run_round("m6v4", s);
`ifndef SPEED_DEBOUNCE_EN
      chk("m6v4.const.b_tie", {31'd0, b_t}, 1);
      chk("m6v4.const.a_right", {31'd0, a_r}, 1);
`endif
      clear_pat();
      add_pushes(1'b1, 0, 2, 7);
      add_pushes(1'b0, 0, 2, 4);
      run_round("m7v4", s);
`ifndef SPEED_DEBOUNCE_EN
      chk("m7v4.const.b_right", {31'd0, b_r}, 1);
`endif

      // 10 left pushes saturate the 3-bit counter at 7.
      clear_pat();
      add_pushes(1'b0, 0, 2, 10);
      run_round("sat", s);
`ifndef SPEED_DEBOUNCE_EN
      chk("sat.const.c_cl", {29'd0, c_cl}, 7);
      chk("sat.const.c_left", {31'd0, c_l}, 1);
`endif

      // Left held all round; right pushes land in COMPARE and in DONE.
      clear_pat();
      for (int j = 0; j < 32; j++) pl[j] = 1'b1;
      pr[14] = 1'b1;
      pr[17] = 1'b1;
      run_round("held", s);
`ifndef SPEED_DEBOUNCE_EN
      chk("held.const.a_cl", {24'd0, a_cl}, 1);
      chk("held.const.a_cr", {24'd0, a_cr}, 0);
`endif

      // Push whose pulse hits the last counting cycle is counted.
      clear_pat();
      pr[13] = 1'b1;
      pr[16] = 1'b1;
      run_round("last", s);
`ifndef SPEED_DEBOUNCE_EN
      chk("last.const.a_cr", {24'd0, a_cr}, 1);
`endif

      // Randomised rounds.
      for (int k = 0; k < 12; k++) begin
         rand_pat();
         run_round($sformatf("rand%0d", k), s);
      end

      // Abort mid-COUNT together with start: abort wins.
      rand_pat();
      idle(8);
      speed_start = 1'b1;
      pbl = pl[0];
      pbr = pr[0];
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         speed_start = 1'b0;
         pbl = pl[j];
         pbr = pr[j];
      end
      speed_abort = 1'b1;
      speed_start = 1'b1;
      @(negedge clk);
      speed_abort = 1'b0;
      speed_start = 1'b0;
      pbl = 1'b0;
      pbr = 1'b0;
      check_idle("abort.a", a_busy, a_rv, a_r, a_l, a_t, a_cl, a_cr);
      check_idle("abort.b", b_busy, b_rv, b_r, b_l, b_t, b_cl, b_cr);
      check_idle("abort.c", c_busy, c_rv, c_r, c_l, c_t, c_cl, c_cr);
      repeat (3) @(negedge clk);
      check_idle("abort.stay.a", a_busy, a_rv, a_r, a_l, a_t, a_cl, a_cr);

      // A round after abort, then reset while in DONE.
      rand_pat();
      run_round("postabort", s);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("rstdone.a", a_busy, a_rv, a_r, a_l, a_t, a_cl, a_cr);
      check_idle("rstdone.b", b_busy, b_rv, b_r, b_l, b_t, b_cl, b_cr);
      check_idle("rstdone.c", c_busy, c_rv, c_r, c_l, c_t, c_cl, c_cr);

`ifdef SPEED_DEBOUNCE_EN
      // A 3-cycle glitch is shorter than the filter and never counts.
      clear_pat();
      pl[0] = 1'b1;
      pl[1] = 1'b1;
      pl[2] = 1'b1;
      add_pushes(1'b1, 0, 1, 6);
      run_round("glitch", s);
      chk("glitch.const.a_cl", {24'd0, a_cl}, 0);
      chk("glitch.const.a_cr", {24'd0, a_cr}, 1);
`endif

      idle(4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
